// File: rtl/alu32_result_stage.sv
// alu32_result_stage: captures the ALU result with {N,Z,C,V} flags into a small
// valid/ready FIFO that decouples the ALU datapath from register-file write-back.
module alu32_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_arith,
  input  logic                     in_c,
  input  logic                     in_v,
  input  logic                     flag_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH+3:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             cq, vq, push, pop;
  logic [1:0]       cv;
  logic [3:0]       flags;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Logic ops inherit the last arithmetic C/V; a same-cycle clear zeroes them first.
  assign cv        = in_arith ? {in_c, in_v} : (flag_clr ? 2'b00 : {cq, vq});
  assign flags     = {in_result[WIDTH-1], in_result == '0, cv};
  assign {out_result, out_flags} = mem[rp];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      cq    <= 1'b0;
      vq    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {in_result, flags};
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push && in_arith) {cq, vq} <= {in_c, in_v};
      else if (flag_clr) {cq, vq} <= 2'b00;
    end
  end
endmodule

// File: tb/tb_alu32_result_stage.sv
// tb_alu32_result_stage: directed stimulus with a scoreboard queue of expected
// result/flag entries, compared whenever the consumer takes the head entry.
module tb_alu32_result_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0, in_arith = 1'b0, in_c = 1'b0, in_v = 1'b0;
  logic             flag_clr = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_result = '0;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [1:0]       count;
  logic [35:0]      q[$];
  logic             mcq = 1'b0, mcv = 1'b0;
  int               n_assert = 0, n_fail = 0, n_pops = 0;

  alu32_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_arith(in_arith), .in_c(in_c), .in_v(in_v),
    .flag_clr(flag_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic step();
    logic       push, pop;
    logic [1:0] cv;
    logic [35:0] ent;
    @(negedge clk);
    chk("out_valid", 36'(out_valid), 36'(q.size() != 0));
    chk("count", 36'(count), 36'(q.size()));
    chk("in_ready", 36'(in_ready), 36'(q.size() != DEPTH));
    if (q.size() != 0) chk("head", {out_result, out_flags}, q[0]);
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() > 0);
    cv   = in_arith ? {in_c, in_v} : (flag_clr ? 2'b00 : {mcq, mcv});
    ent  = {in_result, in_result[WIDTH-1], in_result == 0, cv};
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      n_pops++;
    end
    if (push) q.push_back(ent);
    if (push && in_arith) {mcq, mcv} = {in_c, in_v};
    else if (flag_clr) {mcq, mcv} = 2'b00;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic a,
                       input logic c, input logic ov, input logic clr, input logic rdy);
    in_valid = v; in_result = r; in_arith = a; in_c = c; in_v = ov;
    flag_clr = clr; out_ready = rdy;
  endtask

  initial begin
    // Reset held with a pending producer: nothing may be captured.
    drive(1, 32'h1234, 1, 1, 1, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 36'(out_valid), 36'(0));
    chk("rst_count", 36'(count), 36'(0));
    chk("rst_in_ready", 36'(in_ready), 36'(1));
    chk("rst_flags", 36'(out_flags), 36'(0));
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    // Single arithmetic push of zero with carry.
    drive(1, 32'h0, 1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("arith_valid", 36'(out_valid), 36'(1));
    chk("arith_result", 36'(out_result), 36'(0));
    chk("arith_flags", 36'(out_flags), 36'(4'b0110));
    chk("arith_count", 36'(count), 36'(1));
    // Carry-forward: arith then logic, consumer draining.
    drive(1, 32'h8000_0000, 1, 0, 1, 0, 1);
    step();
    chk("cf_arith_flags", 36'(out_flags), 36'(4'b1001));
    drive(1, 32'h0000_00FF, 0, 1, 0, 0, 1);
    step();
    chk("cf_logic_flags", 36'(out_flags), 36'(4'b0001));
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    // Backpressure: three offers into a two-entry buffer.
    drive(1, 32'hA1, 0, 0, 0, 0, 0);
    step();
    drive(1, 32'hA2, 0, 0, 0, 0, 0);
    step();
    chk("full_count", 36'(count), 36'(2));
    chk("full_in_ready", 36'(in_ready), 36'(0));
    drive(1, 32'hA3, 1, 0, 0, 0, 0);
    step();
    chk("full_hold_count", 36'(count), 36'(2));
    out_ready = 1'b1;
    step();
    chk("free_count", 36'(count), 36'(1));
    chk("free_in_ready", 36'(in_ready), 36'(1));
    out_ready = 1'b0;
    step();
    chk("held_head", 36'(out_result), 36'(32'hA2));
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step();
    // Streaming with pointer wrap.
    n_pops = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 32'(i), i[0], i[1], i[2], 0, 1);
      step();
      if (i > 1) chk("stream_count", 36'(count), 36'(1));
    end
    chk("stream_pops", 36'(n_pops), 36'(19));
    chk("stream_last", 36'(out_result), 36'(20));
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    // flag_clr coinciding with a logic push.
    drive(1, 32'h5, 1, 1, 1, 0, 0);
    step();
    chk("pre_clr_flags", 36'(out_flags), 36'(4'b0011));
    drive(1, 32'h7, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    chk("clr_entry_flags", 36'(out_flags), 36'(4'b0000));
    drive(1, 32'hFFFF_FFFF, 0, 1, 1, 0, 0);
    step();
    chk("mid_count", 36'(count), 36'(2));
    // Asynchronous reset mid-stream.
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", 36'(count), 36'(0));
    chk("async_valid", 36'(out_valid), 36'(0));
    q.delete();
    {mcq, mcv} = 2'b00;
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1, 32'h0000_0042, 0, 1, 1, 0, 0);
    step();
    chk("post_rst_flags", 36'(out_flags), 36'(4'b0000));
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end
endmodule
